disp_scan_ctrl: RTL



---
 rtl/disp_pkg.sv | 40 ++++
 rtl/hex7seg.sv | 19 +
 rtl/disp_scan_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pkg
//  Purpose  : Shared definitions for the multiplexed 7-segment display logic:
//             digit-scan state encoding, blank code and hex-to-segment table.
//  Revision : 1.0  initial release
// ============================================================================
package disp_pkg;

    // Digit-scan states; D1 is the leftmost digit (snap[15:12]).
    typedef enum logic [1:0] {
        D1 = 2'd0,
        D2 = 2'd1,
        D3 = 2'd2,
        D4 = 2'd3
    } state_t;

    // All segments and the decimal point off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g,dp}, indexed by hex value 0..F; dp always off.
    localparam logic [0:15][7:0] SEG_TABLE = {
        8'h03, 8'h9F, 8'h25, 8'h0D,
        8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1,
        8'h63, 8'h85, 8'h61, 8'h71
    };

    // Picks the nibble that a given digit position displays.
    function automatic logic [3:0] nibble_sel(input logic [15:0] val, input state_t d);
        case (d)
            D1:      return val[15:12];
            D2:      return val[11:8];
            D3:      return val[7:4];
            default: return val[3:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex7seg
//  Purpose  : Combinational hex digit to active-low 7-segment code
//             {a,b,c,d,e,f,g,dp}; decimal point is always off.
//  Revision : 1.0  initial release
// ============================================================================
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [7:0] o_seg
);

    // Straight table lookup; the table already carries dp=1.
    assign o_seg = SEG_TABLE[i_hex];

endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : disp_scan_ctrl
//  Purpose  : Scans a 4-digit multiplexed 7-segment display showing one of
//             four 16-bit observation sources. A snapshot is taken once per
//             frame so all four digits always belong to the same value.
//  Revision : 1.0  initial release
// ============================================================================
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  sw,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    output logic [7:0]  dispcode,
    output logic        sign_1,
    output logic        sign_2,
    output logic        sign_3,
    output logic        sign_4,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(SCAN_DIV - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_tick;
    // Set on the edge the scan wraps D4->D1; the following edge is the one
    // that presents the first digit of the new frame, so the snapshot and
    // the D1 code are both taken from the live source on that edge.
    logic               r_new_frame;
    logic               w_new_frame_nxt;
    logic [15:0]        r_snap;
    logic [15:0]        w_src_sel;
    logic [15:0]        w_disp_val;
    logic [3:0]         w_nibble;
    logic [7:0]         w_seg;
    logic [3:0]         w_sign_nxt;     // {sign_1, sign_2, sign_3, sign_4}
    logic [3:0]         r_sign;
    logic [7:0]         r_dispcode;
    logic               r_frame_start;

    // Source multiplexer driven by the switch setting.
    always_comb begin
        w_src_sel = src0;
        case (sw)
            2'b00:   w_src_sel = src0;
            2'b01:   w_src_sel = src1;
            2'b10:   w_src_sel = src2;
            default: w_src_sel = src3;
        endcase
    end

    // Divider, next digit state and next digit-enable pattern.
    always_comb begin
        w_tick          = (r_cnt == c_LAST);
        w_cnt_nxt       = w_tick ? '0 : r_cnt + 1'b1;
        w_state_nxt     = r_state;
        w_new_frame_nxt = w_tick && (r_state == D4);
        w_sign_nxt      = 4'b1111;
        if (w_tick) begin
            case (r_state)
                D1:      w_state_nxt = D2;
                D2:      w_state_nxt = D3;
                D3:      w_state_nxt = D4;
                default: w_state_nxt = D1;
            endcase
        end
        case (r_state)
            D1:      w_sign_nxt = 4'b0111;
            D2:      w_sign_nxt = 4'b1011;
            D3:      w_sign_nxt = 4'b1101;
            default: w_sign_nxt = 4'b1110;
        endcase
    end

    // The D1 digit of a fresh frame bypasses the stale snapshot.
    assign w_disp_val = r_new_frame ? w_src_sel : r_snap;
    assign w_nibble   = nibble_sel(w_disp_val, r_state);

    hex7seg u_hex7seg (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    // Scan state and divider registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= D1;
            r_cnt       <= '0;
            r_new_frame <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_new_frame <= w_new_frame_nxt;
        end
    end

    // Snapshot capture and registered display outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_snap        <= w_src_sel;
            r_sign        <= 4'b1111;
            r_dispcode    <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            if (r_new_frame) begin
                r_snap <= w_src_sel;
            end
            r_sign        <= w_sign_nxt;
            r_dispcode    <= w_seg;
            r_frame_start <= r_new_frame;
        end
    end

    assign dispcode    = r_dispcode;
    assign sign_1      = r_sign[3];
    assign sign_2      = r_sign[2];
    assign sign_3      = r_sign[1];
    assign sign_4      = r_sign[0];
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
